// File: rtl/synth_pkg.sv
// Shared constants, types and helpers for the PWM voice mixer.
// Optional build macro used by the top level: VOICE_ENABLE_MASK_EN.
package synth_pkg;

  localparam int NUM_VOICES      = 8;
  localparam int VOICE_CNT_WIDTH = 16;

  typedef struct packed {
    logic [VOICE_CNT_WIDTH-1:0] cnt;
    logic                       phase;
  } voice_state_t;

  // Left shift that maps a voice count (0..8) onto a PWM_BITS-wide frame.
  function automatic int DUTY_SHIFT(input int pwm_bits);
    return pwm_bits - 3;
  endfunction

  function automatic logic [3:0] popcount8(input logic [NUM_VOICES-1:0] bits);
    logic [3:0] sum_v;
    sum_v = 4'd0;
    for (int i = 0; i < NUM_VOICES; i++) begin
      sum_v = sum_v + {3'd0, bits[i]};
    end
    return sum_v;
  endfunction

endpackage

// File: rtl/pwm_voice_mixer_voice_osc.sv
// Single square-wave voice: half-period counter plus phase flip-flop.
// A zero half-period or a low enable holds the voice muted at phase 0.
module voice_osc
  import synth_pkg::*;
(
  input  logic                       clk,
  input  logic                       rst,
  input  logic [VOICE_CNT_WIDTH-1:0] half_period,
  input  logic                       enable,
  output logic                       phase
);

  voice_state_t state_r;
  voice_state_t state_next_s;

  // Next-state: mute, toggle at end of half period, or count.
  always_comb begin
    state_next_s = state_r;
    if (!enable || (half_period == 16'd0)) begin
      state_next_s.cnt   = 16'd0;
      state_next_s.phase = 1'b0;
    end else if (state_r.cnt >= (half_period - 16'd1)) begin
      // >= lets a shrinking period take effect on the very next edge
      state_next_s.cnt   = 16'd0;
      state_next_s.phase = ~state_r.phase;
    end else begin
      state_next_s.cnt   = state_r.cnt + 16'd1;
      state_next_s.phase = state_r.phase;
    end
  end

  // Voice state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r.cnt   <= 16'd0;
      state_r.phase <= 1'b0;
    end else begin
      state_r <= state_next_s;
    end
  end

  assign phase = state_r.phase;

endmodule

// File: rtl/pwm_voice_mixer.sv
// Eight free-running square-wave voices mixed into one PWM audio bit.
// Define VOICE_ENABLE_MASK_EN to add the per-voice voice_en input.
module pwm_voice_mixer
  import synth_pkg::*;
#(
  parameter int PWM_BITS  = 8,
  parameter int DIV_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DIV_WIDTH-1:0] pwm_reg0,
  input  logic [DIV_WIDTH-1:0] pwm_reg1,
  input  logic [DIV_WIDTH-1:0] pwm_reg2,
  input  logic [DIV_WIDTH-1:0] pwm_reg3,
  input  logic [DIV_WIDTH-1:0] pwm_reg4,
  input  logic [DIV_WIDTH-1:0] pwm_reg5,
  input  logic [DIV_WIDTH-1:0] pwm_reg6,
  input  logic [DIV_WIDTH-1:0] pwm_reg7,
`ifdef VOICE_ENABLE_MASK_EN
  input  logic [7:0]           voice_en,
`endif
  output logic                 pwm_out,
  output logic                 frame_strobe,
  output logic [3:0]           mix_level,
  output logic [7:0]           voice_phase
);

  localparam logic [PWM_BITS-1:0] CNT_LAST = {PWM_BITS{1'b1}};
  localparam logic [PWM_BITS-1:0] CNT_ONE  = {{(PWM_BITS-1){1'b0}}, 1'b1};

  logic [DIV_WIDTH-1:0]  half_period_s [NUM_VOICES];
  logic [NUM_VOICES-1:0] enable_s;
  logic [NUM_VOICES-1:0] voice_phase_s;

  logic [PWM_BITS-1:0]   pwm_cnt_r;
  logic [PWM_BITS:0]     duty_q_r;
  logic [3:0]            mix_level_r;
  logic                  pwm_out_r;
  logic                  frame_strobe_r;

  logic                  frame_end_s;
  logic [PWM_BITS:0]     duty_next_s;
  logic                  pwm_high_s;

  assign half_period_s[0] = pwm_reg0;
  assign half_period_s[1] = pwm_reg1;
  assign half_period_s[2] = pwm_reg2;
  assign half_period_s[3] = pwm_reg3;
  assign half_period_s[4] = pwm_reg4;
  assign half_period_s[5] = pwm_reg5;
  assign half_period_s[6] = pwm_reg6;
  assign half_period_s[7] = pwm_reg7;

`ifdef VOICE_ENABLE_MASK_EN
  assign enable_s = voice_en;
`else
  assign enable_s = {NUM_VOICES{1'b1}};
`endif

  for (genvar g = 0; g < NUM_VOICES; g++) begin : g_voice
    voice_osc u_voice_osc (
      .clk         (clk),
      .rst         (rst),
      .half_period (half_period_s[g]),
      .enable      (enable_s[g]),
      .phase       (voice_phase_s[g])
    );
  end

  // Frame boundary detect, duty candidate and PWM compare.
  always_comb begin
    frame_end_s = 1'b0;
    duty_next_s = {(PWM_BITS+1){1'b0}};
    pwm_high_s  = 1'b0;
    if (pwm_cnt_r == CNT_LAST) begin
      frame_end_s = 1'b1;
    end else begin
      frame_end_s = 1'b0;
    end
    // Level 8 maps to 2**PWM_BITS, hence the extra duty bit.
    duty_next_s = (PWM_BITS+1)'(mix_level_r) << DUTY_SHIFT(PWM_BITS);
    pwm_high_s  = ({1'b0, pwm_cnt_r} < duty_q_r);
  end

  // Mixer, frame counter, frame-aligned duty latch and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mix_level_r    <= 4'd0;
      pwm_cnt_r      <= {PWM_BITS{1'b0}};
      duty_q_r       <= {(PWM_BITS+1){1'b0}};
      frame_strobe_r <= 1'b0;
      pwm_out_r      <= 1'b0;
    end else begin
      mix_level_r    <= popcount8(voice_phase_s);
      pwm_cnt_r      <= pwm_cnt_r + CNT_ONE;
      if (frame_end_s) begin
        duty_q_r <= duty_next_s;
      end else begin
        duty_q_r <= duty_q_r;
      end
      frame_strobe_r <= frame_end_s;
      pwm_out_r      <= pwm_high_s;
    end
  end

  assign pwm_out      = pwm_out_r;
  assign frame_strobe = frame_strobe_r;
  assign mix_level    = mix_level_r;
  assign voice_phase  = voice_phase_s;

endmodule

// File: tb/tb_pwm_voice_mixer.sv
// Directed self-checking bench for pwm_voice_mixer (PWM_BITS=8).
// Build with VOICE_ENABLE_MASK_EN defined to also exercise the voice_en mask.
module tb_pwm_voice_mixer;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] pwm_reg [8];
  logic        pwm_out;
  logic        frame_strobe;
  logic [3:0]  mix_level;
  logic [7:0]  voice_phase;
`ifdef VOICE_ENABLE_MASK_EN
  logic [7:0]  voice_en = 8'hFF;
`endif

  int checks = 0;
  int errors = 0;

  pwm_voice_mixer dut (
    .clk          (clk),
    .rst          (rst),
    .pwm_reg0     (pwm_reg[0]),
    .pwm_reg1     (pwm_reg[1]),
    .pwm_reg2     (pwm_reg[2]),
    .pwm_reg3     (pwm_reg[3]),
    .pwm_reg4     (pwm_reg[4]),
    .pwm_reg5     (pwm_reg[5]),
    .pwm_reg6     (pwm_reg[6]),
    .pwm_reg7     (pwm_reg[7]),
`ifdef VOICE_ENABLE_MASK_EN
    .voice_en     (voice_en),
`endif
    .pwm_out      (pwm_out),
    .frame_strobe (frame_strobe),
    .mix_level    (mix_level),
    .voice_phase  (voice_phase)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic set_regs(input logic [15:0] v);
    for (int i = 0; i < 8; i++) pwm_reg[i] = v;
  endtask

  // Reset asserted for 3 cycles; released on a falling edge so edge 1 follows.
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int high_cnt;
    int bad;
    int strobes;
    logic [7:0] exp_ph;
    logic [3:0] exp_mix;

    set_regs(16'd0);

    // T1: asynchronous reset and idle behaviour
    #1 rst = 1'b1;
    #2;
    check("t1_async_pwm_out", 32'(pwm_out), 32'd0);
    check("t1_async_strobe", 32'(frame_strobe), 32'd0);
    check("t1_async_mix", 32'(mix_level), 32'd0);
    check("t1_async_phase", 32'(voice_phase), 32'd0);
    repeat (3) @(negedge clk);
    check("t1_rst_outputs", 32'({pwm_out, frame_strobe, mix_level, voice_phase}), 32'd0);
    rst = 1'b0;
    high_cnt = 0; bad = 0; strobes = 0;
    for (int k = 1; k <= 2000; k++) begin
      @(negedge clk);
      if (pwm_out) high_cnt++;
      if (frame_strobe !== ((k % 256) == 0)) bad++;
      if (frame_strobe) strobes++;
    end
    check("t1_pwm_high_cycles", 32'(high_cnt), 32'd0);
    check("t1_strobe_timing_errs", 32'(bad), 32'd0);
    check("t1_strobe_count", 32'(strobes), 32'd7);

    // T2: voice 0 with half period 4
    set_regs(16'd0);
    pwm_reg[0] = 16'd4;
    do_reset();
    high_cnt = 0; bad = 0;
    for (int k = 1; k <= 600; k++) begin
      @(negedge clk);
      exp_ph  = 8'((k / 4) & 1);
      exp_mix = 4'(((k - 1) / 4) & 1);
      if (voice_phase !== exp_ph) bad++;
      if (mix_level !== exp_mix) bad++;
      if (k >= 257 && k <= 512 && pwm_out) high_cnt++;
      if (k == 4) check("t2_phase_edge4", 32'(voice_phase), 32'd1);
      if (k == 8) check("t2_phase_edge8", 32'(voice_phase), 32'd0);
      if (k == 256) check("t2_duty_frame1", 32'(dut.duty_q_r), 32'd32);
    end
    check("t2_phase_mix_errs", 32'(bad), 32'd0);
    check("t2_pwm_high_frame", 32'(high_cnt), 32'd32);

    // T3: all voices in step, full-scale level
    set_regs(16'd1000);
    do_reset();
    high_cnt = 0;
    for (int k = 1; k <= 1300; k++) begin
      @(negedge clk);
      if (k == 999) check("t3_phase_before", 32'(voice_phase), 32'd0);
      if (k == 1000) check("t3_phase_all_high", 32'(voice_phase), 32'hFF);
      if (k == 1100) check("t3_mix_full", 32'(mix_level), 32'd8);
      if (k == 1024) check("t3_duty_full", 32'(dut.duty_q_r), 32'd256);
      if (k >= 1025 && k <= 1280 && pwm_out) high_cnt++;
    end
    check("t3_pwm_high_frame", 32'(high_cnt), 32'd256);

    // T4: shrink the half period mid-count, then mute
    set_regs(16'd0);
    pwm_reg[0] = 16'd100;
    do_reset();
    bad = 0;
    for (int k = 1; k <= 100; k++) begin
      @(negedge clk);
      if (k >= 51 && k <= 90) exp_ph = 8'((((k - 51) / 10) & 1) == 0);
      else exp_ph = 8'd0;
      if (voice_phase !== exp_ph) bad++;
      if (k == 51) check("t4_toggle_next_edge", 32'(voice_phase), 32'd1);
      if (k == 61) check("t4_toggle_new_period", 32'(voice_phase), 32'd0);
      if (k == 91) check("t4_muted", 32'(voice_phase), 32'd0);
      if (k == 50) pwm_reg[0] = 16'd10;
      if (k == 90) pwm_reg[0] = 16'd0;
    end
    check("t4_phase_errs", 32'(bad), 32'd0);

    // T5: asynchronous reset pulse between edges, mid-frame
    set_regs(16'd0);
    pwm_reg[0] = 16'd1000;
    pwm_reg[1] = 16'd1000;
    pwm_reg[2] = 16'd1000;
    do_reset();
    repeat (1064) @(negedge clk);
    check("t5_pre_mix", 32'(mix_level), 32'd3);
    check("t5_pre_cnt", 32'(dut.pwm_cnt_r), 32'd40);
    check("t5_pre_duty", 32'(dut.duty_q_r), 32'd96);
    check("t5_pre_pwm_out", 32'(pwm_out), 32'd1);
    #1 rst = 1'b1;
    #1;
    check("t5_rst_outputs", 32'({pwm_out, frame_strobe, mix_level, voice_phase}), 32'd0);
    check("t5_rst_cnt", 32'(dut.pwm_cnt_r), 32'd0);
    check("t5_rst_duty", 32'(dut.duty_q_r), 32'd0);
    #1 rst = 1'b0;
    @(negedge clk);
    check("t5_restart_cnt", 32'(dut.pwm_cnt_r), 32'd1);
    check("t5_restart_phase", 32'(voice_phase), 32'd0);

`ifdef VOICE_ENABLE_MASK_EN
    // T6: only voice 0 enabled, then all voices enabled together
    set_regs(16'd3);
    voice_en = 8'h01;
    do_reset();
    bad = 0;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      exp_ph = 8'((k / 3) & 1);
      if (voice_phase !== exp_ph) bad++;
      if (mix_level > 4'd1) bad++;
    end
    check("t6_masked_errs", 32'(bad), 32'd0);
    voice_en = 8'hFF;
    @(negedge clk);
    check("t6_enable_edge31", 32'(voice_phase), 32'h00);
    @(negedge clk);
    check("t6_enable_edge32", 32'(voice_phase), 32'h00);
    @(negedge clk);
    check("t6_enable_edge33", 32'(voice_phase), 32'hFF);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
